regfile: RTL and testbench
==========================

# regfile

General-purpose register file for the MIPS datapath, the write-side consumer of the writeback stage's `regf_w` port. Holds 32 × 32-bit GPRs with `$0` hardwired to zero. Provides two combinational read ports with same-cycle write-through bypass. Keeps a per-register pending-write scoreboard that decode uses to detect read-after-write hazards and stall.

## Interface

Parameters:
- `PEND_W`, default 2. Width of each per-register pending-write counter; maximum in-flight writers per register is 2^PEND_W−1.

Ports:
- `clk`  in  1  Clock. All state updates on the rising edge.
- `rst`  in  1  Reset, asynchronous, active-high.
- `rd`  `regf_w.slave`  5+32  Write port from writeback. `rd.regf` selects the destination; `rd.regf==0` means no write. `rd.data` is the write data.
- `rs_regf`  in  5  Read port A index.
- `rs_data`  out  32  Read port A data.
- `rs_busy`  out  1  Register `rs_regf` has an outstanding writer.
- `rt_regf`  in  5  Read port B index.
- `rt_data`  out  32  Read port B data.
- `rt_busy`  out  1  Register `rt_regf` has an outstanding writer.
- `claim_regf`  in  5  Destination of the instruction leaving decode this cycle; 0 means none.
- `flush`  in  1  Clears every pending counter; asserted when all in-flight instructions are killed.

## Operation

- Storage: `gpr[1..31]`, 32 bits each. `gpr[0]` is not stored and always reads 0.
- Write: at the rising edge, if `rd.regf != 0`, `gpr[rd.regf] <= rd.data`.
- Read, port A (port B identical):
  - `rs_regf==0` → 0.
  - `rs_regf==rd.regf` and `rd.regf != 0` → `rd.data` (bypass).
  - Otherwise → `gpr[rs_regf]`.
- Pending counters: `cnt[1..31]`, each `PEND_W` bits. `cnt[0]` is constant 0.
- Next-state of `cnt[r]` for r ≠ 0:
  - `flush` → 0. Flush has priority over claim and release in the same cycle.
  - else `+1` if `claim_regf==r`, and `−1` if `rd.regf==r`.
  - Claim and release to the same r in one cycle leave the counter unchanged.
- Saturation:
  - Release at `cnt==0` leaves it at 0. This covers stale writebacks arriving after a flush; the data write still happens.
  - Claim at `cnt==max` leaves it at max. This is a protocol violation; the bench flags it with an assertion.
- Busy: `rs_busy = (cnt[rs_regf] − (rd.regf==rs_regf && rs_regf!=0 ? 1 : 0)) != 0`. The writer retiring this cycle does not count, since its data is already bypassed. Same rule for `rt_busy`. Index 0 is never busy.
- A same-cycle claim does not affect busy outputs. It becomes visible the next cycle.

## Timing

- Reset (async): all `gpr` are 0 and all `cnt` are 0. As a result, `rs_data`, `rt_data`, `rs_busy` and `rt_busy` are all 0 while `rst` is high and immediately after.
- `rst` asserted mid-operation clears state immediately, regardless of `clk`. Writes and claims presented during reset are dropped.
- Read latency is 0 cycles: the data and busy outputs are purely combinational from the indices, the `rd` port and current state.
- A write becomes visible combinationally in the cycle it is presented (bypass). From the next cycle it comes from storage.
- A claim in cycle N sets busy from cycle N+1. The matching release in cycle M clears busy from cycle M, via the busy rule.
- A flush in cycle N clears busy from cycle N+1.

## Test plan

- Reset then read: hold `rst` for 2 cycles; set `rs_regf=5`, `rt_regf=31` → both data outputs 0 and both busy outputs 0. A write of 0xDEADBEEF to `$5` during `rst` is dropped, so `rs_data` still reads 0 after release.
- Write/bypass: present `rd.regf=7`, `rd.data=0x12345678` with `rs_regf=7` → `rs_data=0x12345678` in the same cycle. Next cycle, with `rd.regf=0`, it still reads 0x12345678. A write to `$0` with 0xFFFFFFFF leaves `$0` reading 0.
- Scoreboard: claim `$9` in cycle 1 → `rs_busy=1` (with `rs_regf=9`) from cycle 2. Claim `$9` again in cycle 2; release in cycle 4 → busy stays 1. Release in cycle 6 → busy is 0 in cycle 6 and `rs_data` equals that writeback's data.
- Simultaneous claim+release: `$3` at `cnt=1`; claim `$3` and write `$3`=0xA5 in the same cycle → next cycle `cnt=1` and busy=1, data reads 0xA5.
- Flush: claim `$4`, `$8`, `$4`; assert `flush` together with a claim of `$8` → next cycle all busy are 0. A later stale write to `$4`=0x55 updates the data and `cnt[4]` stays 0.
- Async reset mid-run: after writing `$10`=0x77 and claiming `$10`, pulse `rst` between clock edges → `rt_data` (with `rt_regf=10`) and `rt_busy` drop to 0 immediately.

Source files
------------

// File: rtl/regfile_if.sv
// Writeback-to-register-file write port: destination index plus data.
// A destination of 0 means no write this cycle.
interface regf_w;
  logic [4:0]  regf;
  logic [31:0] data;

  modport master (output regf, output data);
  modport slave  (input  regf, input  data);
endinterface

// File: rtl/regfile.sv
// MIPS general-purpose register file: 31 stored 32-bit GPRs ($0 reads zero),
// two combinational read ports with write-through bypass, and a per-register
// pending-write scoreboard used by decode for RAW hazard detection.
module regfile #(
  parameter int unsigned PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  regf_w.slave        rd,
  input  logic [4:0]  rs_regf,
  output logic [31:0] rs_data,
  output logic        rs_busy,
  input  logic [4:0]  rt_regf,
  output logic [31:0] rt_data,
  output logic        rt_busy,
  input  logic [4:0]  claim_regf,
  input  logic        flush
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [31:0]       gpr_q [1:31];
  logic [31:0]       gpr_d [1:31];
  logic [PEND_W-1:0] cnt_q [1:31];
  logic [PEND_W-1:0] cnt_d [1:31];

  // Full 32-entry views with index 0 pinned to zero, for indexed reads.
  logic [31:0]       rf_view  [32];
  logic [PEND_W-1:0] cnt_view [32];

  logic wr_en;
  logic rs_rel;
  logic rt_rel;
  logic [PEND_W-1:0] rs_cnt;
  logic [PEND_W-1:0] rt_cnt;

  // Write port is live only for a nonzero destination outside reset.
  always_comb begin
    wr_en = (rd.regf != 5'd0) && !rst;
  end

  // Next-state of the GPR storage.
  always_comb begin
    for (int unsigned i = 1; i < 32; i++) begin
      gpr_d[i] = gpr_q[i];
      if (wr_en && (rd.regf == 5'(i)))
        gpr_d[i] = rd.data;
    end
  end

  // Next-state of the pending-write counters; flush wins, then a claim and
  // release to the same register cancel, otherwise saturate at 0 / max.
  always_comb begin
    for (int unsigned i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if ((claim_regf == 5'(i)) && !(rd.regf == 5'(i))) begin
        if (cnt_q[i] != CNT_MAX)
          cnt_d[i] = cnt_q[i] + 1'b1;
      end else if ((rd.regf == 5'(i)) && !(claim_regf == 5'(i))) begin
        if (cnt_q[i] != '0)
          cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < 32; i++) begin
        gpr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < 32; i++) begin
        gpr_q[i] <= gpr_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Zero-extended views of storage and counters.
  always_comb begin
    rf_view[0]  = '0;
    cnt_view[0] = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      rf_view[i]  = gpr_q[i];
      cnt_view[i] = cnt_q[i];
    end
  end

  // Read ports with bypass of the retiring writer.
  always_comb begin
    rs_rel = wr_en && (rd.regf == rs_regf);
    rt_rel = wr_en && (rd.regf == rt_regf);

    if (rs_regf == 5'd0)  rs_data = '0;
    else if (rs_rel)      rs_data = rd.data;
    else                  rs_data = rf_view[rs_regf];

    if (rt_regf == 5'd0)  rt_data = '0;
    else if (rt_rel)      rt_data = rd.data;
    else                  rt_data = rf_view[rt_regf];
  end

  // Busy: outstanding writers excluding the one retiring now. Compared rather
  // than subtracted so a stale release against an empty counter cannot wrap.
  always_comb begin
    rs_cnt  = cnt_view[rs_regf];
    rt_cnt  = cnt_view[rt_regf];
    rs_busy = rs_cnt > PEND_W'(rs_rel);
    rt_busy = rt_cnt > PEND_W'(rt_rel);
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table plus hand-written
// reset sequences.
module tb_regfile;

  localparam int unsigned PEND_W = 2;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_regf;
  logic [31:0] rs_data;
  logic        rs_busy;
  logic [4:0]  rt_regf;
  logic [31:0] rt_data;
  logic        rt_busy;
  logic [4:0]  claim_regf;
  logic        flush;

  regf_w rd_if ();

  regfile #(.PEND_W(PEND_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd         (rd_if),
    .rs_regf    (rs_regf),
    .rs_data    (rs_data),
    .rs_busy    (rs_busy),
    .rt_regf    (rt_regf),
    .rt_data    (rt_data),
    .rt_busy    (rt_busy),
    .claim_regf (claim_regf),
    .flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shadow of the pending counters, used only to flag claims beyond max.
  logic [PEND_W-1:0] pend [32];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) pend[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) pend[i] <= '0;
    end else begin
      if (claim_regf != 0 && rd_if.regf != claim_regf && pend[claim_regf] != '1)
        pend[claim_regf] <= pend[claim_regf] + 1'b1;
      if (rd_if.regf != 0 && rd_if.regf != claim_regf && pend[rd_if.regf] != '0)
        pend[rd_if.regf] <= pend[rd_if.regf] - 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!rst && !flush && claim_regf != 0 && rd_if.regf != claim_regf)
      assert (pend[claim_regf] != '1)
        else $error("claim of $%0d beyond pending-writer limit", claim_regf);
  end

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  wr;
    logic [31:0] wdata;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  claim;
    logic        fl;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic        exp_rsb;
    logic        exp_rtb;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic [4:0] wr, input logic [31:0] wdata,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] claim, input logic fl,
                     input logic [31:0] exp_rs, input logic [31:0] exp_rt,
                     input logic exp_rsb, input logic exp_rtb);
    vec_t v;
    v.wr = wr; v.wdata = wdata; v.rs = rs; v.rt = rt; v.claim = claim; v.fl = fl;
    v.exp_rs = exp_rs; v.exp_rt = exp_rt; v.exp_rsb = exp_rsb; v.exp_rtb = exp_rtb;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    rd_if.regf = '0; rd_if.data = '0; claim_regf = '0; flush = 1'b0;
  endtask

  initial begin
    // Each row is one cycle: inputs driven, outputs checked, then a clock edge.
    //   wr   wdata         rs   rt   clm  fl  exp_rs        exp_rt        rsb  rtb
    add(5'd7,  32'h12345678, 5'd7, 5'd0, 5'd0, 0, 32'h12345678, 32'h0,        0, 0);
    add(5'd0,  32'h0,        5'd7, 5'd7, 5'd0, 0, 32'h12345678, 32'h12345678, 0, 0);
    add(5'd0,  32'hFFFFFFFF, 5'd0, 5'd7, 5'd0, 0, 32'h0,        32'h12345678, 0, 0);
    add(5'd0,  32'h0,        5'd0, 5'd0, 5'd0, 0, 32'h0,        32'h0,        0, 0);
    // Scoreboard on $9: two claims, two releases.
    add(5'd0,  32'h0,        5'd9, 5'd0, 5'd9, 0, 32'h0,        32'h0,        0, 0);
    add(5'd0,  32'h0,        5'd9, 5'd0, 5'd9, 0, 32'h0,        32'h0,        1, 0);
    add(5'd0,  32'h0,        5'd9, 5'd0, 5'd0, 0, 32'h0,        32'h0,        1, 0);
    add(5'd9,  32'h00001111, 5'd9, 5'd0, 5'd0, 0, 32'h00001111, 32'h0,        1, 0);
    add(5'd0,  32'h0,        5'd9, 5'd0, 5'd0, 0, 32'h00001111, 32'h0,        1, 0);
    add(5'd9,  32'h00002222, 5'd9, 5'd9, 5'd0, 0, 32'h00002222, 32'h00002222, 0, 0);
    add(5'd0,  32'h0,        5'd9, 5'd0, 5'd0, 0, 32'h00002222, 32'h0,        0, 0);
    // Simultaneous claim and release on $3 at cnt=1.
    add(5'd0,  32'h0,        5'd0, 5'd3, 5'd3, 0, 32'h0,        32'h0,        0, 0);
    add(5'd3,  32'h000000A5, 5'd3, 5'd3, 5'd3, 0, 32'h000000A5, 32'h000000A5, 0, 0);
    add(5'd0,  32'h0,        5'd3, 5'd0, 5'd0, 0, 32'h000000A5, 32'h0,        1, 0);
    add(5'd3,  32'h000000B6, 5'd3, 5'd0, 5'd0, 0, 32'h000000B6, 32'h0,        0, 0);
    // Flush with a concurrent claim, then a stale writeback.
    add(5'd0,  32'h0,        5'd4, 5'd8, 5'd4, 0, 32'h0,        32'h0,        0, 0);
    add(5'd0,  32'h0,        5'd4, 5'd8, 5'd8, 0, 32'h0,        32'h0,        1, 0);
    add(5'd0,  32'h0,        5'd4, 5'd8, 5'd4, 0, 32'h0,        32'h0,        1, 1);
    add(5'd0,  32'h0,        5'd4, 5'd8, 5'd8, 1, 32'h0,        32'h0,        1, 1);
    add(5'd0,  32'h0,        5'd4, 5'd8, 5'd0, 0, 32'h0,        32'h0,        0, 0);
    add(5'd4,  32'h00000055, 5'd4, 5'd8, 5'd0, 0, 32'h00000055, 32'h0,        0, 0);
    add(5'd0,  32'h0,        5'd4, 5'd4, 5'd0, 0, 32'h00000055, 32'h00000055, 0, 0);
    // Top register index.
    add(5'd31, 32'hCAFEF00D, 5'd31, 5'd1, 5'd0, 0, 32'hCAFEF00D, 32'h0,       0, 0);
    add(5'd0,  32'h0,        5'd31, 5'd31, 5'd0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);

    // Reset with a write and claim presented; both must be dropped.
    rst = 1'b1;
    rs_regf = 5'd5; rt_regf = 5'd31;
    rd_if.regf = 5'd5; rd_if.data = 32'hDEADBEEF;
    claim_regf = 5'd5; flush = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      check("rst_rs_data", 0, rs_data, 32'h0);
      check("rst_rt_data", 0, rt_data, 32'h0);
      check("rst_rs_busy", 0, 32'(rs_busy), 32'h0);
      check("rst_rt_busy", 0, 32'(rt_busy), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    check("post_rst_rs_data", 0, rs_data, 32'h0);
    check("post_rst_rs_busy", 0, 32'(rs_busy), 32'h0);
    check("post_rst_rt_data", 0, rt_data, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rd_if.regf = vecs[i].wr; rd_if.data = vecs[i].wdata;
      rs_regf = vecs[i].rs; rt_regf = vecs[i].rt;
      claim_regf = vecs[i].claim; flush = vecs[i].fl;
      #1;
      check("rs_data", i, rs_data, vecs[i].exp_rs);
      check("rt_data", i, rt_data, vecs[i].exp_rt);
      check("rs_busy", i, 32'(rs_busy), 32'(vecs[i].exp_rsb));
      check("rt_busy", i, 32'(rt_busy), 32'(vecs[i].exp_rtb));
    end

    // Async reset between clock edges clears data and busy at once.
    @(negedge clk);
    idle_inputs();
    rd_if.regf = 5'd10; rd_if.data = 32'h00000077; rt_regf = 5'd10;
    #1;
    check("mid_bypass", 0, rt_data, 32'h00000077);
    @(negedge clk);
    idle_inputs();
    claim_regf = 5'd10;
    #1;
    check("mid_stored", 0, rt_data, 32'h00000077);
    @(negedge clk);
    idle_inputs();
    #1;
    check("mid_busy", 0, 32'(rt_busy), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async_rt_data", 0, rt_data, 32'h0);
    check("async_rt_busy", 0, 32'(rt_busy), 32'h0);
    #1 rst = 1'b0;
    #1;
    check("after_async_rt_data", 0, rt_data, 32'h0);
    check("after_async_rt_busy", 0, 32'(rt_busy), 32'h0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
